// File: rtl/lcd_hd44780_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_seq_pkg
// Purpose  : Shared types and constants for the HD44780 bus-timing sequencer:
//            FSM state encoding, busy-flag bit position, default phase
//            lengths for a 50 MHz clock, the fixed RS/RW values used for
//            busy-flag reads, and width helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package lcd_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    // Busy flag position in the instruction-register read value
    localparam int BF_BIT = 7;

    // Default phase lengths in 50 MHz clocks (20 ns each)
    localparam int DEF_SETUP_CYC = 2;   // tAS
    localparam int DEF_PULSE_CYC = 12;  // PWEH
    localparam int DEF_HOLD_CYC  = 2;   // tAH / tH
    localparam int DEF_GAP_CYC   = 10;  // recovery so the E cycle is >= 500 ns

    // A busy-flag read is an instruction-register read
    localparam logic POLL_RS = 1'b0;
    localparam logic POLL_RW = 1'b1;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Number of bits needed to hold the value v (at least 1)
    function automatic int bits_for(input int v);
        if (v <= 1) return 1;
        return $clog2(v + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_hd44780_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : lcd_hd44780_sequencer_if
// Purpose  : Command/response channel between the register slave and the
//            LCD sequencer.
// Signals  : cmd_valid/cmd_ready  - one-command-at-a-time handshake
//            cmd_rs, cmd_rw       - register select, read(1)/write(0)
//            cmd_data[7:0]        - write data
//            rsp_valid            - one-cycle completion pulse
//            rsp_data[7:0]        - read data (0x00 for writes)
//            busy_timeout         - sticky busy-flag polling timeout
// Modports : master (command issuer), slave (sequencer)
// Revision : 1.0 - initial release
// ============================================================================
interface lcd_hd44780_sequencer_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rs;
    logic       cmd_rw;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy_timeout;

    modport master (
        output cmd_valid, cmd_rs, cmd_rw, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, busy_timeout
    );

    modport slave (
        input  cmd_valid, cmd_rs, cmd_rw, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, busy_timeout
    );

endinterface
`default_nettype wire

// File: rtl/lcd_hd44780_sequencer_timer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_phase_timer
// Purpose  : Loadable down-counter that times one bus phase. Loading N-1 on
//            the transition into a phase makes done_o assert in the N-th
//            (last) cycle of that phase. done_next_o is the value done_o
//            will have in the following cycle, letting the parent register
//            outputs that must coincide with a phase's last cycle.
// Ports    : clk, reset_n      - clock, asynchronous active-low reset
//            load_i            - load load_val_i this cycle
//            load_val_i[W-1:0] - phase length minus one
//            done_o            - counter is zero
//            done_next_o       - counter will be zero next cycle
// Revision : 1.0 - initial release
// ============================================================================
module lcd_phase_timer #(
    parameter int WIDTH = 4
) (
    input  wire              clk,
    input  wire              reset_n,
    input  wire              load_i,
    input  wire  [WIDTH-1:0] load_val_i,
    output logic             done_o,
    output logic             done_next_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o      = (count_q == '0);
    assign done_next_o = (count_d == '0);

endmodule
`default_nettype wire

// File: rtl/lcd_hd44780_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_hd44780_sequencer
// Purpose  : Self-timed HD44780 bus cycle generator. Accepts one command at a
//            time, drives RS/RW/data setup, the E pulse, hold and recovery
//            phases, and optionally polls the busy flag after each write.
// Ports    : clk, reset_n        - clock, asynchronous active-low reset
//            cmd_if (slave)      - command/response channel
//            LCD_E, LCD_RS,
//            LCD_RW              - LCD control pins (registered)
//            LCD_data[7:0]       - LCD data bus, tristated here
// Revision : 1.0 - initial release
// ============================================================================
module lcd_hd44780_sequencer
    import lcd_seq_pkg::*;
#(
    parameter int SETUP_CYC  = DEF_SETUP_CYC,
    parameter int PULSE_CYC  = DEF_PULSE_CYC,
    parameter int HOLD_CYC   = DEF_HOLD_CYC,
    parameter int GAP_CYC    = DEF_GAP_CYC,
    parameter int BUSY_POLL  = 1,
    parameter int POLL_LIMIT = 4096
) (
    input  wire                    clk,
    input  wire                    reset_n,
    lcd_hd44780_sequencer_if.slave cmd_if,
    output logic                   LCD_E,
    output logic                   LCD_RS,
    output logic                   LCD_RW,
    inout  wire  [7:0]             LCD_data
);

    localparam int c_TIMER_W = bits_for(max_of4(SETUP_CYC, PULSE_CYC, HOLD_CYC, GAP_CYC) - 1);
    localparam int c_POLL_W  = bits_for(POLL_LIMIT);

    localparam logic [c_TIMER_W-1:0] c_SETUP_LD = c_TIMER_W'(SETUP_CYC - 1);
    localparam logic [c_TIMER_W-1:0] c_PULSE_LD = c_TIMER_W'(PULSE_CYC - 1);
    localparam logic [c_TIMER_W-1:0] c_HOLD_LD  = c_TIMER_W'(HOLD_CYC - 1);
    localparam logic [c_TIMER_W-1:0] c_GAP_LD   = c_TIMER_W'(GAP_CYC - 1);
    localparam logic [c_POLL_W-1:0]  c_POLL_LIM = c_POLL_W'(POLL_LIMIT);
    localparam logic                 c_POLL_EN  = (BUSY_POLL != 0);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_e              state_q,    state_d;
    logic                rs_q,       rs_d;
    logic                rw_q,       rw_d;
    logic [7:0]          data_q,     data_d;
    logic                polling_q,  polling_d;
    logic [c_POLL_W-1:0] poll_cnt_q, poll_cnt_d;
    logic                bf_q,       bf_d;
    logic [7:0]          rd_data_q,  rd_data_d;

    // Registered outputs
    logic                lcd_e_q,        lcd_e_d;
    logic                lcd_rs_q,       lcd_rs_d;
    logic                lcd_rw_q,       lcd_rw_d;
    logic                drv_q,          drv_d;
    logic                cmd_ready_q,    cmd_ready_d;
    logic                rsp_valid_q,    rsp_valid_d;
    logic [7:0]          rsp_data_q,     rsp_data_d;
    logic                busy_timeout_q, busy_timeout_d;

    logic                   w_load;
    logic [c_TIMER_W-1:0]   w_load_val;
    logic                   w_timer_done;
    logic                   w_timer_done_next;
    logic                   w_accept;
    logic                   w_below_limit;
    logic                   w_poll_more;
    logic                   w_active_d;
    logic                   w_rs_eff_d;
    logic                   w_rw_eff_d;

    lcd_phase_timer #(
        .WIDTH (c_TIMER_W)
    ) u_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .load_i      (w_load),
        .load_val_i  (w_load_val),
        .done_o      (w_timer_done),
        .done_next_o (w_timer_done_next)
    );

    // The poll counter only advances when below the limit, so it
    // saturates at POLL_LIMIT by construction.
    assign w_below_limit = (poll_cnt_q < c_POLL_LIM);

    // Decided from registered state only, so it is stable throughout GAP:
    // a finished write starts the first poll, a busy poll starts another.
    assign w_poll_more = polling_q ? (bf_q && w_below_limit)
                                   : (!rw_q && c_POLL_EN && w_below_limit);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        rs_d       = rs_q;
        rw_d       = rw_q;
        data_d     = data_q;
        polling_d  = polling_q;
        poll_cnt_d = poll_cnt_q;
        bf_d       = bf_q;
        rd_data_d  = rd_data_q;
        w_load     = 1'b0;
        w_load_val = '0;
        w_accept   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_if.cmd_valid && cmd_ready_q) begin
                    w_accept   = 1'b1;
                    rs_d       = cmd_if.cmd_rs;
                    rw_d       = cmd_if.cmd_rw;
                    data_d     = cmd_if.cmd_data;
                    polling_d  = 1'b0;
                    poll_cnt_d = '0;
                    state_d    = ST_SETUP;
                    w_load     = 1'b1;
                    w_load_val = c_SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (w_timer_done) begin
                    state_d    = ST_PULSE;
                    w_load     = 1'b1;
                    w_load_val = c_PULSE_LD;
                end
            end
            ST_PULSE: begin
                if (w_timer_done) begin
                    // Last E-high cycle: capture read data
                    if (polling_q) begin
                        bf_d = LCD_data[BF_BIT];
                    end else if (rw_q) begin
                        rd_data_d = LCD_data;
                    end
                    state_d    = ST_HOLD;
                    w_load     = 1'b1;
                    w_load_val = c_HOLD_LD;
                end
            end
            ST_HOLD: begin
                if (w_timer_done) begin
                    state_d    = ST_GAP;
                    w_load     = 1'b1;
                    w_load_val = c_GAP_LD;
                end
            end
            ST_GAP: begin
                if (w_timer_done) begin
                    if (w_poll_more) begin
                        polling_d  = 1'b1;
                        poll_cnt_d = poll_cnt_q + 1'b1;
                        state_d    = ST_SETUP;
                        w_load     = 1'b1;
                        w_load_val = c_SETUP_LD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output next values: computed from next state so every pin and
    // handshake output comes straight from a flop.
    // ------------------------------------------------------------------
    always_comb begin
        w_active_d = (state_d == ST_SETUP) || (state_d == ST_PULSE) || (state_d == ST_HOLD);
        w_rs_eff_d = polling_d ? POLL_RS : rs_d;
        w_rw_eff_d = polling_d ? POLL_RW : rw_d;

        lcd_e_d     = (state_d == ST_PULSE);
        lcd_rs_d    = w_active_d ? w_rs_eff_d : 1'b0;
        lcd_rw_d    = w_active_d ? w_rw_eff_d : 1'b1;
        drv_d       = w_active_d && !w_rw_eff_d;
        cmd_ready_d = (state_d == ST_IDLE);

        // Flag the cycle that will be the final GAP cycle of the command
        rsp_valid_d = (state_d == ST_GAP) && w_timer_done_next && !w_poll_more;

        rsp_data_d = rsp_data_q;
        if (rsp_valid_d) begin
            rsp_data_d = rw_q ? rd_data_q : 8'h00;
        end

        // Finishing while a poll still reads busy means the limit was hit
        busy_timeout_d = busy_timeout_q;
        if (w_accept) begin
            busy_timeout_d = 1'b0;
        end else if (rsp_valid_d && polling_q && bf_q) begin
            busy_timeout_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            rs_q           <= 1'b0;
            rw_q           <= 1'b1;
            data_q         <= 8'h00;
            polling_q      <= 1'b0;
            poll_cnt_q     <= '0;
            bf_q           <= 1'b0;
            rd_data_q      <= 8'h00;
            lcd_e_q        <= 1'b0;
            lcd_rs_q       <= 1'b0;
            lcd_rw_q       <= 1'b1;
            drv_q          <= 1'b0;
            cmd_ready_q    <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_data_q     <= 8'h00;
            busy_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rs_q           <= rs_d;
            rw_q           <= rw_d;
            data_q         <= data_d;
            polling_q      <= polling_d;
            poll_cnt_q     <= poll_cnt_d;
            bf_q           <= bf_d;
            rd_data_q      <= rd_data_d;
            lcd_e_q        <= lcd_e_d;
            lcd_rs_q       <= lcd_rs_d;
            lcd_rw_q       <= lcd_rw_d;
            drv_q          <= drv_d;
            cmd_ready_q    <= cmd_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_data_q     <= rsp_data_d;
            busy_timeout_q <= busy_timeout_d;
        end
    end

    assign LCD_E    = lcd_e_q;
    assign LCD_RS   = lcd_rs_q;
    assign LCD_RW   = lcd_rw_q;
    assign LCD_data = drv_q ? data_q : 8'hzz;

    assign cmd_if.cmd_ready    = cmd_ready_q;
    assign cmd_if.rsp_valid    = rsp_valid_q;
    assign cmd_if.rsp_data     = rsp_data_q;
    assign cmd_if.busy_timeout = busy_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_hd44780_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_hd44780_sequencer
// Purpose  : Self-checking bench. dut0 runs with busy polling disabled,
//            dut1 with polling enabled and POLL_LIMIT=4. Expected responses
//            are queued when a command is accepted; a monitor compares each
//            rsp_valid pulse (cycle, data, timeout) against the queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_hd44780_sequencer;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       to;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];

    // ---------------- DUT 0: no busy polling ----------------
    lcd_hd44780_sequencer_if if0();
    logic       e0, rs0, rw0;
    wire  [7:0] bus0;

    lcd_hd44780_sequencer #(
        .SETUP_CYC (2), .PULSE_CYC (12), .HOLD_CYC (2), .GAP_CYC (10),
        .BUSY_POLL (0), .POLL_LIMIT (4096)
    ) dut0 (
        .clk      (clk),
        .reset_n  (reset_n),
        .cmd_if   (if0.slave),
        .LCD_E    (e0),
        .LCD_RS   (rs0),
        .LCD_RW   (rw0),
        .LCD_data (bus0)
    );

    // LCD model: answers reads with 0x41 while E is high
    assign bus0 = (rw0 && e0) ? 8'h41 : 8'hzz;

    // ---------------- DUT 1: busy polling, limit 4 ----------------
    lcd_hd44780_sequencer_if if1();
    logic       e1, rs1, rw1;
    wire  [7:0] bus1;
    int         poll_seen = 0;
    int         poll_rs_bad = 0;
    int         poll_base = 0;
    int         bf_n = 0;
    logic [7:0] mdl1_val;

    lcd_hd44780_sequencer #(
        .SETUP_CYC (2), .PULSE_CYC (12), .HOLD_CYC (2), .GAP_CYC (10),
        .BUSY_POLL (1), .POLL_LIMIT (4)
    ) dut1 (
        .clk      (clk),
        .reset_n  (reset_n),
        .cmd_if   (if1.slave),
        .LCD_E    (e1),
        .LCD_RS   (rs1),
        .LCD_RW   (rw1),
        .LCD_data (bus1)
    );

    // LCD model: reports busy for the first bf_n polls after poll_base
    assign mdl1_val = ((poll_seen - poll_base) < bf_n) ? 8'h80 : 8'h00;
    assign bus1     = (rw1 && e1) ? mdl1_val : 8'hzz;

    always @(negedge e1) begin
        if (rw1) begin
            poll_seen = poll_seen + 1;
            if (rs1) poll_rs_bad = poll_rs_bad + 1;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push0(input int c, input logic [7:0] d, input logic to);
        exp_t e;
        e.cyc = c; e.data = d; e.to = to;
        q0.push_back(e);
    endtask

    task automatic push1(input int c, input logic [7:0] d, input logic to);
        exp_t e;
        e.cyc = c; e.data = d; e.to = to;
        q1.push_back(e);
    endtask

    // Called at a negedge; returns the accept cycle, leaves time at cycle 1
    task automatic send0(input logic rs, input logic rw, input logic [7:0] d, output int acc);
        int n;
        if0.cmd_rs = rs; if0.cmd_rw = rw; if0.cmd_data = d; if0.cmd_valid = 1'b1;
        n = 0;
        while (!if0.cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept0", {31'd0, if0.cmd_ready}, 32'd1);
        acc = cyc;
        @(negedge clk);
    endtask

    task automatic send1(input logic rs, input logic rw, input logic [7:0] d, output int acc);
        int n;
        if1.cmd_rs = rs; if1.cmd_rw = rw; if1.cmd_data = d; if1.cmd_valid = 1'b1;
        n = 0;
        while (!if1.cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept1", {31'd0, if1.cmd_ready}, 32'd1);
        acc = cyc;
        @(negedge clk);
    endtask

    // ---------------- monitor ----------------
    task automatic run_monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && if0.rsp_valid) begin
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp0_unexpected: actual rsp_valid=1 at cycle %0d required none", cyc);
                end else begin
                    e = q0.pop_front();
                    chk("rsp0_cycle",   cyc,                          e.cyc);
                    chk("rsp0_data",    {24'd0, if0.rsp_data},        {24'd0, e.data});
                    chk("rsp0_timeout", {31'd0, if0.busy_timeout},    {31'd0, e.to});
                end
            end
            if (reset_n && if1.rsp_valid) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp1_unexpected: actual rsp_valid=1 at cycle %0d required none", cyc);
                end else begin
                    e = q1.pop_front();
                    chk("rsp1_cycle",   cyc,                          e.cyc);
                    chk("rsp1_data",    {24'd0, if1.rsp_data},        {24'd0, e.data});
                    chk("rsp1_timeout", {31'd0, if1.busy_timeout},    {31'd0, e.to});
                end
            end
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic run_stimulus();
        int acc, k, first, last, bad, c0, prev, base_bad;
        logic [1:0] rsrw;
        logic r26, r27;
        int rises[$];

        if0.cmd_valid = 1'b0; if0.cmd_rs = 1'b0; if0.cmd_rw = 1'b0; if0.cmd_data = 8'h00;
        if1.cmd_valid = 1'b0; if1.cmd_rs = 1'b0; if1.cmd_rw = 1'b0; if1.cmd_data = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_e",       {31'd0, e0},               32'd0);
        chk("rst_rs",      {31'd0, rs0},              32'd0);
        chk("rst_rw",      {31'd0, rw0},              32'd1);
        chk("rst_ready",   {31'd0, if0.cmd_ready},    32'd0);
        chk("rst_rsp",     {31'd0, if0.rsp_valid},    32'd0);
        chk("rst_rspdata", {24'd0, if0.rsp_data},     32'd0);
        chk("rst_timeout", {31'd0, if0.busy_timeout}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, if0.cmd_ready}, 32'd1);

        // Write 0x38 to the instruction register
        send0(1'b0, 1'b0, 8'h38, acc);
        push0(acc + 26, 8'h00, 1'b0);
        if0.cmd_valid = 1'b0;
        first = -1; last = -1; bad = 0; rsrw = 2'b11; r26 = 1'b1; r27 = 1'b0;
        while (cyc - acc <= 27) begin
            k = cyc - acc;
            if (e0) begin
                if (first < 0) first = k;
                last = k;
            end
            if (k >= 1 && k <= 16 && bus0 !== 8'h38) bad++;
            if (k == 3)  rsrw = {rs0, rw0};
            if (k == 26) r26 = if0.cmd_ready;
            if (k == 27) r27 = if0.cmd_ready;
            @(negedge clk);
        end
        chk("wr_e_first",   first, 3);
        chk("wr_e_last",    last,  14);
        chk("wr_data_bad",  bad,   0);
        chk("wr_rsrw",      {30'd0, rsrw}, 32'd0);
        chk("wr_ready_t26", {31'd0, r26},  32'd0);
        chk("wr_ready_t27", {31'd0, r27},  32'd1);

        // Read from the data register; the model answers 0x41
        send0(1'b1, 1'b1, 8'h5A, acc);
        push0(acc + 26, 8'h41, 1'b0);
        if0.cmd_valid = 1'b0;
        bad = 0; rsrw = 2'b00;
        while (cyc - acc <= 27) begin
            k = cyc - acc;
            if (k >= 1 && k <= 16 && bus0 === 8'h5A) bad++;
            if (k == 1) rsrw = {rs0, rw0};
            @(negedge clk);
        end
        chk("rd_no_drive", bad, 0);
        chk("rd_rsrw",     {30'd0, rsrw}, 32'd3);

        // Three back-to-back writes with cmd_valid held high
        if0.cmd_rs = 1'b0; if0.cmd_rw = 1'b0; if0.cmd_data = 8'h55; if0.cmd_valid = 1'b1;
        k = 0;
        while (!if0.cmd_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        c0 = cyc;
        push0(c0 + 26, 8'h00, 1'b0);
        push0(c0 + 53, 8'h00, 1'b0);
        push0(c0 + 80, 8'h00, 1'b0);
        prev = 0;
        while (cyc - c0 <= 85) begin
            if (e0 && prev == 0) rises.push_back(cyc - c0);
            prev = e0 ? 1 : 0;
            if (cyc - c0 == 55) if0.cmd_valid = 1'b0;
            @(negedge clk);
        end
        chk("b2b_rise_count", rises.size(), 3);
        if (rises.size() == 3) begin
            chk("b2b_rise0",  rises[0], 3);
            chk("b2b_gap01",  rises[1] - rises[0], 27);
            chk("b2b_gap12",  rises[2] - rises[1], 27);
        end

        // Reset asserted during PULSE: no response may follow
        send0(1'b0, 1'b0, 8'h77, acc);
        if0.cmd_valid = 1'b0;
        while (cyc - acc < 8) @(negedge clk);
        chk("rst_mid_e_before", {31'd0, e0}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_e",     {31'd0, e0}, 32'd0);
        chk("rst_mid_bus_z", {31'd0, (bus0 === 8'h77)}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", {31'd0, if0.cmd_ready}, 32'd1);
        repeat (30) @(negedge clk);

        // dut1: busy for 3 polls, then ready -> 4 polls, rsp at 130
        poll_base = poll_seen; base_bad = poll_rs_bad; bf_n = 3;
        send1(1'b0, 1'b0, 8'h01, acc);
        push1(acc + 130, 8'h00, 1'b0);
        if1.cmd_valid = 1'b0;
        while (cyc - acc <= 132) @(negedge clk);
        chk("poll_count",  poll_seen - poll_base, 4);
        chk("poll_rs",     poll_rs_bad - base_bad, 0);
        chk("poll_no_to",  {31'd0, if1.busy_timeout}, 32'd0);

        // dut1: busy flag stuck -> timeout after 4 polls
        poll_base = poll_seen; bf_n = 1000;
        send1(1'b0, 1'b0, 8'h02, acc);
        push1(acc + 130, 8'h00, 1'b1);
        if1.cmd_valid = 1'b0;
        while (cyc - acc <= 132) @(negedge clk);
        chk("stuck_poll_count", poll_seen - poll_base, 4);
        chk("timeout_sticky",   {31'd0, if1.busy_timeout}, 32'd1);

        // dut1: next command clears the timeout; one poll, not busy
        poll_base = poll_seen; bf_n = 0;
        send1(1'b0, 1'b0, 8'h03, acc);
        push1(acc + 52, 8'h00, 1'b0);
        if1.cmd_valid = 1'b0;
        chk("timeout_cleared", {31'd0, if1.busy_timeout}, 32'd0);
        while (cyc - acc <= 54) @(negedge clk);
        chk("clear_poll_count", poll_seen - poll_base, 1);

        // Drain
        k = 0;
        while ((q0.size() != 0 || q1.size() != 0) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
    endtask

    initial begin
        fork
            run_monitor();
        join_none
        run_stimulus();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute guard against a hung run
    initial begin
        #200000;
        $display("FAIL global_timeout: actual still running required finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
